// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifetch_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
    localparam int          INSTR_BYTES = 4;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO of fetch entries between fetch and decode.
// Storage is not reset; only the pointers and occupancy count are.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wptr;
    logic [PW-1:0]  rptr;
    logic [PW:0]    count;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    // Caller guarantees no push into a full FIFO without a pop, and no pop when empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rptr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads instruction memory and buffers {pc, instr} for decode.
// Optional feature macro IFETCH_MISALIGN_CHECK_EN tags entries after a misaligned redirect.
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter int          ADDR_WIDTH = 5,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           ins_in,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [31:0]           if_instr,
    output logic [31:0]           if_pc,
    output logic                  if_misaligned
);

    logic [31:0]  pc_q;
    logic         push;
    logic         pop;
    logic         full;
    logic         empty;
    fetch_entry_t wr_entry;
    fetch_entry_t head;
    logic         entry_misaligned;

    assign pop  = if_valid && if_ready;
    assign push = !rst && !redirect_valid && (!full || pop);
    assign addr = pc_q[ADDR_WIDTH+1:2];

    // Redirect overrides sequential fetch; the low PC bits are always forced to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            pc_q <= pc_q + 32'(INSTR_BYTES);
        end
    end

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic misalign_flag;

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_flag <= 1'b0;
        end else if (redirect_valid) begin
            misalign_flag <= |redirect_pc[1:0];
        end else if (push) begin
            misalign_flag <= 1'b0;
        end
    end

    assign entry_misaligned = misalign_flag;
    assign if_misaligned    = !empty && head.misaligned;
`else
    logic unused_misalign;
    assign unused_misalign  = ^{redirect_pc[1:0], head.misaligned};
    assign entry_misaligned = 1'b0;
    assign if_misaligned    = 1'b0;
`endif

    assign wr_entry = '{pc: pc_q, instr: ins_in, misaligned: entry_misaligned};

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata (wr_entry),
        .full  (full),
        .empty (empty),
        .head  (head)
    );

    // Unreset storage must not leak onto the outputs while the buffer is empty.
    assign if_valid = !empty;
    assign if_instr = empty ? '0 : head.instr;
    assign if_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed self-checking bench for instr_fetch with a combinational memory model.
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [4:0]  addr;
    logic [31:0] ins_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_misaligned;

    int checks   = 0;
    int failures = 0;

`ifdef IFETCH_MISALIGN_CHECK_EN
    localparam logic EXP_MIS = 1'b1;
`else
    localparam logic EXP_MIS = 1'b0;
`endif

    instr_fetch #(
        .ADDR_WIDTH (5),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .addr           (addr),
        .ins_in         (ins_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_misaligned  (if_misaligned)
    );

    // Memory returns 0x1000_0000 plus the word index.
    assign ins_in = 32'h1000_0000 + 32'(addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then advance to just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic rdy,
                                 input logic rv, input logic [31:0] rpc);
        rst            = r;
        if_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkHead(input string tag, input logic v,
                             input logic [31:0] pc, input logic [31:0] ins);
        checkOutput({tag, "_valid"}, 32'(if_valid), 32'(v));
        if (v) begin
            checkOutput({tag, "_pc"}, if_pc, pc);
            checkOutput({tag, "_instr"}, if_instr, ins);
        end
    endtask

    initial begin
        rst = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        $display("[TB] reset state");
        checkOutput("rst_valid", 32'(if_valid), 32'h0);
        checkOutput("rst_addr", 32'(addr), 32'h0);
        checkOutput("rst_pc", if_pc, 32'h0);
        checkOutput("rst_instr", if_instr, 32'h0);
        checkOutput("rst_mis", 32'(if_misaligned), 32'h0);

        // rst now low: first cycle still empty, valid one cycle later
        rst = 1'b0; if_ready = 1'b1;
        #1;
        checkOutput("post_rst_c0_valid", 32'(if_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("seq0", 1'b1, 32'h0, 32'h1000_0000);
        checkOutput("seq0_addr", 32'(addr), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("seq1", 1'b1, 32'h4, 32'h1000_0001);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("seq2", 1'b1, 32'h8, 32'h1000_0002);

        $display("[TB] decode stall");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkHead("stall", 1'b1, 32'h8, 32'h1000_0002);
            checkOutput("stall_addr", 32'(addr), 32'd4);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("drain0", 1'b1, 32'hC, 32'h1000_0003);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("drain1", 1'b1, 32'h10, 32'h1000_0004);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        checkHead("refill", 1'b1, 32'h10, 32'h1000_0004);

        $display("[TB] redirect while full");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        checkOutput("redir_valid", 32'(if_valid), 32'h0);
        checkOutput("redir_addr", 32'(addr), 32'd16);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("redir0", 1'b1, 32'h40, 32'h1000_0010);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("redir1", 1'b1, 32'h44, 32'h1000_0011);

        $display("[TB] back-to-back redirects");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0020);
        checkOutput("b2b0_valid", 32'(if_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0030);
        checkOutput("b2b1_valid", 32'(if_valid), 32'h0);
        checkOutput("b2b1_addr", 32'(addr), 32'd12);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("b2b_s0", 1'b1, 32'h30, 32'h1000_000C);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("b2b_s1", 1'b1, 32'h34, 32'h1000_000D);

        $display("[TB] address wrap");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_007C);
        checkOutput("wrap_addr0", 32'(addr), 32'd31);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_addr1", 32'(addr), 32'd0);
        checkHead("wrap0", 1'b1, 32'h7C, 32'h1000_001F);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkOutput("wrap_addr2", 32'(addr), 32'd1);
        checkHead("wrap1", 1'b1, 32'h80, 32'h1000_0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("wrap2", 1'b1, 32'h84, 32'h1000_0001);

        $display("[TB] misaligned redirect");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_0042);
        checkOutput("mis_valid", 32'(if_valid), 32'h0);
        checkOutput("mis_addr", 32'(addr), 32'd16);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("mis0", 1'b1, 32'h40, 32'h1000_0010);
        checkOutput("mis0_flag", 32'(if_misaligned), 32'(EXP_MIS));
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
        checkHead("mis1", 1'b1, 32'h44, 32'h1000_0011);
        checkOutput("mis1_flag", 32'(if_misaligned), 32'h0);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("mid_rst_valid", 32'(if_valid), 32'h0);
        checkOutput("mid_rst_addr", 32'(addr), 32'h0);
        checkOutput("mid_rst_pc", if_pc, 32'h0);
        checkOutput("mid_rst_instr", if_instr, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
